atm_session_timer: RTL and testbench

ATM_SESSION_TIMER -- requirements
Module: atm_session_timer

---
 rtl/atm_session_timer.sv | 138 +++++++++++++
 tb/tb_atm_session_timer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_timer.sv
// atm_session_timer: ATM card session watchdog with warning and eject.
// Define ATM_SESSION_BEEP_EN to build the warning-phase beeper.
module atm_session_timer #(
  parameter int TICK_DIV      = 1_000_000,
  parameter int SESSION_TICKS = 3000,
  parameter int WARN_TICKS    = 1000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        card_in,
  input  logic        activity,
  input  logic        done,
  output logic        session_active,
  output logic        warn,
  output logic        timeout_pulse,
  output logic        eject,
  output logic [15:0] remaining,
  output logic        beep
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [15:0] SES = 16'(SESSION_TICKS);
  localparam logic [15:0] WRN = 16'(WARN_TICKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_WARN,
    S_EXPIRED,
    S_EJECT
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic [15:0]   rem_d;
  logic [15:0]   dec;
  logic          card_prev;
  logic          card_armed;
  logic          card_rise;
  logic          in_sess;
  logic          tick;

  // A card left in the slot across reset must be removed first.
  assign card_rise = card_armed && !card_prev && card_in;
  assign in_sess   = (state_q == S_ACTIVE) || (state_q == S_WARN);
  assign tick      = in_sess && (presc_q == PMAX);
  assign dec       = remaining - 16'd1;

  // Next-state, window count and prescaler; card pull beats done beats activity beats tick.
  always_comb begin
    state_d = state_q;
    presc_d = '0;
    rem_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (card_rise) begin
          state_d = S_ACTIVE;
          rem_d   = SES;
        end
      end
      S_ACTIVE, S_WARN: begin
        rem_d   = remaining;
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (!card_in) begin
          state_d = S_IDLE;
          rem_d   = '0;
          presc_d = '0;
        end else if (done) begin
          state_d = S_EJECT;
          rem_d   = '0;
          presc_d = '0;
        end else if (activity) begin
          state_d = S_ACTIVE;
          rem_d   = SES;
          presc_d = '0;
        end else if (tick && remaining != 16'd0) begin
          rem_d = dec;
          if (dec == 16'd0) begin
            state_d = S_EXPIRED;
          end else if (dec == WRN) begin
            state_d = S_WARN;
          end
        end
      end
      S_EXPIRED: state_d = S_EJECT;
      S_EJECT: begin
        if (!card_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      presc_q        <= '0;
      remaining      <= '0;
      card_prev      <= 1'b0;
      card_armed     <= 1'b0;
      session_active <= 1'b0;
      warn           <= 1'b0;
      timeout_pulse  <= 1'b0;
      eject          <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      remaining      <= rem_d;
      card_prev      <= card_in;
      card_armed     <= card_armed | ~card_in;
      session_active <= (state_d == S_ACTIVE) || (state_d == S_WARN);
      warn           <= (state_d == S_WARN);
      timeout_pulse  <= (state_d == S_EXPIRED);
      eject          <= (state_d == S_EJECT);
    end
  end

`ifdef ATM_SESSION_BEEP_EN
  // Beeper toggles on each tick spent in WARN, cleared elsewhere.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      beep <= 1'b0;
    end else if (state_d != S_WARN || state_q != S_WARN) begin
      beep <= 1'b0;
    end else if (tick) begin
      beep <= ~beep;
    end
  end
`else
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_atm_session_timer.sv
// tb_atm_session_timer: scoreboard bench for atm_session_timer.
// Reference model tracks elapsed cycles since the last window reload.
module tb_atm_session_timer;

  localparam int TD  = 4;
  localparam int SES = 6;
  localparam int WRN = 2;

  logic        clk_in   = 1'b0;
  logic        reset    = 1'b1;
  logic        card_in  = 1'b0;
  logic        activity = 1'b0;
  logic        done     = 1'b0;
  logic        session_active;
  logic        warn;
  logic        timeout_pulse;
  logic        eject;
  logic        beep;
  logic [15:0] remaining;

  atm_session_timer #(
    .TICK_DIV(TD),
    .SESSION_TICKS(SES),
    .WARN_TICKS(WRN)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .card_in(card_in),
    .activity(activity),
    .done(done),
    .session_active(session_active),
    .warn(warn),
    .timeout_pulse(timeout_pulse),
    .eject(eject),
    .remaining(remaining),
    .beep(beep)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        sa;
    logic        w;
    logic        tp;
    logic        ej;
    logic        bp;
    logic [15:0] rem;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  typedef enum {M_IDLE, M_SESS, M_EXP, M_EJ} mmode_t;
  mmode_t m_mode = M_IDLE;
  int     m_el   = 0;
  bit     m_arm  = 1'b0;
  bit     m_prev = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_rem();
    return (m_mode == M_SESS) ? SES - m_el / TD : 0;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_el   = 0;
    m_arm  = 1'b0;
    m_prev = 1'b0;
  endfunction

  function automatic void model_step(input bit rst, input bit c,
                                     input bit a, input bit d);
    if (rst) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (m_arm && !m_prev && c) begin
          m_mode = M_SESS;
          m_el   = 0;
        end
      end
      M_SESS: begin
        if (!c) m_mode = M_IDLE;
        else if (d) m_mode = M_EJ;
        else if (a) m_el = 0;
        else begin
          m_el++;
          if (m_rem() == 0) m_mode = M_EXP;
        end
      end
      M_EXP: m_mode = M_EJ;
      M_EJ: if (!c) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
    if (!c) m_arm = 1'b1;
    m_prev = c;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   r;
    r     = m_rem();
    e.sa  = (m_mode == M_SESS);
    e.w   = e.sa && (r <= WRN);
    e.tp  = (m_mode == M_EXP);
    e.ej  = (m_mode == M_EJ);
    e.rem = 16'(r);
`ifdef ATM_SESSION_BEEP_EN
    e.bp  = e.w && (((WRN - r) % 2) == 1);
`else
    e.bp  = 1'b0;
`endif
    return e;
  endfunction

  task automatic cyc(input bit c, input bit a, input bit d);
    card_in  = c;
    activity = a;
    done     = d;
    @(posedge clk_in);
    model_step(reset, c, a, d);
    sb_q.push_back(model_out());
    #2;
  endtask

  task automatic do_reset(input bit c);
    @(negedge clk_in);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_session_active", 16'(session_active), 16'd0);
    chk("rst_warn", 16'(warn), 16'd0);
    chk("rst_timeout_pulse", 16'(timeout_pulse), 16'd0);
    chk("rst_eject", 16'(eject), 16'd0);
    chk("rst_beep", 16'(beep), 16'd0);
    chk("rst_remaining", remaining, 16'd0);
    model_reset();
    cyc(c, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic run_until(input int target);
    int n;
    n = 0;
    while (!(m_mode == M_SESS && m_rem() == target) && n < 64) begin
      cyc(1'b1, 1'b0, 1'b0);
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL run_until: remaining %0d not reached, expected within 64 cycles",
               target);
    end
  endtask

  // Monitor: one expected output set per clock, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("session_active", 16'(session_active), 16'(e.sa));
        chk("warn", 16'(warn), 16'(e.w));
        chk("timeout_pulse", 16'(timeout_pulse), 16'(e.tp));
        chk("eject", 16'(eject), 16'(e.ej));
        chk("beep", 16'(beep), 16'(e.bp));
        chk("remaining", remaining, e.rem);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // Hold card with no activity until expiry and eject.
    repeat (31) cyc(1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // Activity late in WARN reloads the window.
    cyc(1'b1, 1'b0, 1'b0);
    run_until(1);
    cyc(1'b1, 1'b1, 1'b0);
    repeat (12) cyc(1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // done together with activity ejects.
    cyc(1'b1, 1'b0, 1'b0);
    run_until(4);
    cyc(1'b1, 1'b1, 1'b1);
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // Card pulled mid-session.
    cyc(1'b1, 1'b0, 1'b0);
    run_until(3);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);

    // Reset in WARN with card held, then re-insert.
    cyc(1'b1, 1'b0, 1'b0);
    run_until(1);
    do_reset(1'b1);
    repeat (6) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (30) cyc(1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        cyc($urandom_range(0, 29) != 0,
            $urandom_range(0, 13) == 0,
            $urandom_range(0, 49) == 0);
      end
    end
    cyc(1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk_in);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
